sdcard_arbiter: RTL and testbench

SDCARD_ARBITER -- requirements
Module: sdcard_arbiter

---
 rtl/sdcard_arbiter_if.sv | 33 +++
 rtl/sdcard_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdcard_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdcard_arbiter_if.sv
// Groups the SD-card arbiter's request/grant, SPI drive and card-pin signals.
// Latency: none, this is a plain signal bundle.
// Backpressure: none; the slave modport is the arbiter, master is the controller/bench side.
//
// Ports (arbiter view): sdreq_i/sdack_o per-controller request/grant, cs_i/mosi_i/sclk_i
// per-controller SPI drive, miso_o broadcast, sdcard_* card pins, owner_o, busy_o,
// tmo_err_o sticky timeout flag, err_clr_i flag clear.
interface sdcard_arbiter_if;
  logic [3:0] sdreq_i;
  logic [3:0] sdack_o;
  logic [3:0] cs_i;
  logic [3:0] mosi_i;
  logic [3:0] sclk_i;
  logic       miso_o;
  logic       sdcard_cs;
  logic       sdcard_mosi;
  logic       sdcard_sclk;
  logic       sdcard_miso;
  logic [1:0] owner_o;
  logic       busy_o;
  logic       tmo_err_o;
  logic       err_clr_i;

  modport slave (
    input  sdreq_i, cs_i, mosi_i, sclk_i, sdcard_miso, err_clr_i,
    output sdack_o, miso_o, sdcard_cs, sdcard_mosi, sdcard_sclk, owner_o, busy_o, tmo_err_o
  );

  modport master (
    output sdreq_i, cs_i, mosi_i, sclk_i, sdcard_miso, err_clr_i,
    input  sdack_o, miso_o, sdcard_cs, sdcard_mosi, sdcard_sclk, owner_o, busy_o, tmo_err_o
  );
endinterface

// File: rtl/sdcard_arbiter.sv
// Round-robin arbiter sharing one SPI SD card between four controllers, with guard gap and watchdog.
// Latency: grant one edge after an eligible request; card pins follow the owner combinationally.
// Backpressure: a controller holds sdreq_i until sdack_o; a hog is cut off and locked out by the watchdog.
//
// Ports: clk_p clock, sys_init_n async active-low reset, bus (sdcard_arbiter_if.slave) carrying
// requests/grants, per-controller SPI lines, card pins, owner/busy status and the timeout flag.
module sdcard_arbiter #(
  parameter int GUARD = 4,   // idle cycles between grants, 1..255
  parameter int TMO_W = 24   // watchdog width
) (
  input  logic            clk_p,
  input  logic            sys_init_n,
  sdcard_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam logic [TMO_W-1:0] WD_MAX   = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] WD_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       GUARD_LD = GUARD[7:0];

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       lock_q, lock_d;
  logic [3:0]       ack_q, ack_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             tmo_q, tmo_d;

  logic [3:0]       elig;
  logic             found;
  logic [1:0]       pick;
  logic [1:0]       scan_idx;
  logic [TMO_W-1:0] wd_inc;
  logic             set_err;
  logic             grant_act;

  always_ff @(posedge clk_p or negedge sys_init_n) begin
    if (!sys_init_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      lock_q  <= 4'd0;
      ack_q   <= 4'd0;
      wd_q    <= '0;
      gcnt_q  <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      ack_q   <= ack_d;
      wd_q    <= wd_d;
      gcnt_q  <= gcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    ack_d    = ack_q;
    wd_d     = wd_q;
    gcnt_d   = gcnt_q;
    set_err  = 1'b0;
    // A lock only survives while its controller keeps requesting.
    lock_d   = lock_q & bus.sdreq_i;

    // Rotating scan starting at ptr; first eligible channel wins.
    elig     = bus.sdreq_i & ~lock_q;
    found    = 1'b0;
    pick     = ptr_q;
    scan_idx = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!found && elig[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end

    // Watchdog value counts completed granted cycles; expiry is when that count hits all-ones.
    wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + WD_ONE;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d = pick;
          ack_d   = 4'b0001 << pick;
          wd_d    = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        wd_d = wd_inc;
        if (!bus.sdreq_i[owner_q] || (wd_inc == WD_MAX)) begin
          ack_d   = 4'd0;
          ptr_d   = owner_q + 2'd1;
          gcnt_d  = GUARD_LD;
          state_d = ST_GUARD;
          // A request dropped on the expiry edge is an ordinary release.
          if (bus.sdreq_i[owner_q]) begin
            set_err         = 1'b1;
            lock_d[owner_q] = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        gcnt_d = gcnt_q - 8'd1;
        if (gcnt_q <= 8'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Set beats clear when both land on the same edge.
    tmo_d = tmo_q;
    if (set_err) begin
      tmo_d = 1'b1;
    end else if (bus.err_clr_i) begin
      tmo_d = 1'b0;
    end
  end

  // Pins derive from registered state only, so an async reset releases them immediately.
  assign grant_act       = (state_q == ST_GRANT);
  assign bus.sdack_o     = ack_q;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.tmo_err_o   = tmo_q;
  assign bus.miso_o      = bus.sdcard_miso;
  assign bus.sdcard_cs   = grant_act ? bus.cs_i[owner_q]   : 1'b1;
  assign bus.sdcard_mosi = grant_act ? bus.mosi_i[owner_q] : 1'b1;
  assign bus.sdcard_sclk = grant_act ? bus.sclk_i[owner_q] : 1'b0;

endmodule

// File: tb/tb_sdcard_arbiter.sv
// Self-checking bench for sdcard_arbiter: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the arbitration rules.
// Inputs change mid-cycle; outputs are sampled 4 time units after each rising edge.
module tb_sdcard_arbiter;
  localparam int GUARD_P = 4;
  localparam int TMO_P   = 4;
  localparam int TMO_LIM = (1 << TMO_P) - 1;

  logic clk_p = 1'b0;
  logic sys_init_n;
  int   n_vec = 0;
  int   n_err = 0;

  sdcard_arbiter_if bus ();

  sdcard_arbiter #(.GUARD(GUARD_P), .TMO_W(TMO_P)) dut (
    .clk_p      (clk_p),
    .sys_init_n (sys_init_n),
    .bus        (bus)
  );

  always #5 clk_p = ~clk_p;

  // Behavioural model: who holds the card, how long they have held it, gap remaining.
  bit       m_act;
  int       m_own;
  int       m_held;
  int       m_gap;
  int       m_next;
  bit [3:0] m_lock;
  bit       m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_own = 0; m_held = 0; m_gap = 0; m_next = 0; m_lock = 4'd0; m_err = 1'b0;
  endtask

  task automatic release_card();
    m_act  = 1'b0;
    m_gap  = GUARD_P;
    m_next = (m_own + 1) % 4;
  endtask

  task automatic model_step();
    logic [3:0] req;
    bit [3:0]   nl;
    bit         set;
    bit         done;
    req  = bus.sdreq_i;
    nl   = m_lock & req;
    set  = 1'b0;
    done = 1'b0;
    if (m_act) begin
      m_held++;
      if (!req[m_own]) begin
        release_card();
      end else if (m_held == TMO_LIM) begin
        release_card();
        set = 1'b1;
        nl[m_own] = 1'b1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_next + k) % 4;
        if (!done && req[c] && !m_lock[c]) begin
          done = 1'b1; m_act = 1'b1; m_own = c; m_held = 0;
        end
      end
    end
    m_lock = nl;
    if (set) m_err = 1'b1;
    else if (bus.err_clr_i) m_err = 1'b0;
  endtask

  task automatic check_all();
    logic [3:0] e_ack;
    logic [2:0] e_pins;
    e_ack  = m_act ? (4'b0001 << m_own) : 4'b0000;
    e_pins = m_act ? {bus.cs_i[m_own], bus.mosi_i[m_own], bus.sclk_i[m_own]} : 3'b110;
    chk("ack", 32'(bus.sdack_o), 32'(e_ack));
    chk("onehot", 32'($countones(bus.sdack_o) <= 1), 32'd1);
    chk("owner", 32'(bus.owner_o), 32'(m_own));
    chk("busy", 32'(bus.busy_o), 32'(m_act || (m_gap > 0)));
    chk("tmo_err", 32'(bus.tmo_err_o), 32'(m_err));
    chk("pins", 32'({bus.sdcard_cs, bus.sdcard_mosi, bus.sdcard_sclk}), 32'(e_pins));
    chk("miso", 32'(bus.miso_o), 32'(bus.sdcard_miso));
  endtask

  task automatic cycle();
    @(posedge clk_p);
    model_step();
    #1;
    bus.cs_i        = 4'($urandom);
    bus.mosi_i      = 4'($urandom);
    bus.sclk_i      = 4'($urandom);
    bus.sdcard_miso = 1'($urandom);
    #3;
    check_all();
  endtask

  // Called mid-cycle: asserts reset, checks outputs before any clock edge, releases later.
  task automatic do_reset(input string tag);
    sys_init_n = 1'b0;
    #2;
    chk({tag, "_ack"}, 32'(bus.sdack_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_owner"}, 32'(bus.owner_o), 32'd0);
    chk({tag, "_tmo"}, 32'(bus.tmo_err_o), 32'd0);
    chk({tag, "_pins"}, 32'({bus.sdcard_cs, bus.sdcard_mosi, bus.sdcard_sclk}), 32'h6);
    model_reset();
    #10;
    sys_init_n = 1'b1;
  endtask

  // Runs until a grant appears, counting guard cycles (busy, no ack) on the way.
  task automatic wait_grant(input string tag, output int guard_cnt);
    int t;
    t = 0;
    guard_cnt = 0;
    while (bus.sdack_o == 4'b0 && t < 40) begin
      if (bus.busy_o) guard_cnt++;
      chk({tag, "_gap_cs"}, 32'(bus.sdcard_cs), 32'd1);
      cycle();
      t++;
    end
    chk({tag, "_grant_seen"}, 32'(bus.sdack_o != 4'b0), 32'd1);
  endtask

  task automatic hold_cnt(output int n);
    n = 0;
    while (bus.sdack_o != 4'b0 && n < 40) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    int gc;
    int n;
    bit seen2;
    bus.sdreq_i     = 4'd0;
    bus.cs_i        = 4'hF;
    bus.mosi_i      = 4'hF;
    bus.sclk_i      = 4'h0;
    bus.sdcard_miso = 1'b0;
    bus.err_clr_i   = 1'b0;
    sys_init_n      = 1'b1;
    model_reset();
    #1;
    do_reset("rst0");

    // Single request straight after reset: grant on the first edge, pins follow ch0.
    bus.sdreq_i = 4'b0001;
    cycle();
    chk("t1_ack", 32'(bus.sdack_o), 32'h1);
    chk("t1_owner", 32'(bus.owner_o), 32'd0);
    repeat (3) begin
      cycle();
      chk("t1_pins_ch0", 32'({bus.sdcard_cs, bus.sdcard_mosi, bus.sdcard_sclk}),
          32'({bus.cs_i[0], bus.mosi_i[0], bus.sclk_i[0]}));
    end
    bus.sdreq_i = 4'b0000;
    cycle();
    chk("t1_release", 32'(bus.sdack_o), 32'h0);
    repeat (6) cycle();

    // All four requesting: round-robin 0,1,2,3,0 with GUARD guard cycles between grants.
    do_reset("rst1");
    bus.sdreq_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int own;
      own = g % 4;
      wait_grant("t2", gc);
      chk("t2_order", 32'(bus.owner_o), 32'(own));
      chk("t2_ack", 32'(bus.sdack_o), 32'(4'b0001 << own));
      if (g > 0) chk("t2_guard_len", 32'(gc), 32'(GUARD_P));
      repeat (9) cycle();
      chk("t2_still_held", 32'(bus.sdack_o), 32'(4'b0001 << own));
      bus.sdreq_i[own] = 1'b0;
      cycle();
      chk("t2_drop", 32'(bus.sdack_o), 32'h0);
      bus.sdreq_i[own] = 1'b1;
    end
    bus.sdreq_i = 4'b0000;
    repeat (8) cycle();

    // ch2 hogs the card: cut off after 15 cycles, locked, ch1 served after the guard.
    bus.sdreq_i = 4'b0100;
    wait_grant("t3a", gc);
    chk("t3_owner2", 32'(bus.owner_o), 32'd2);
    bus.sdreq_i[1] = 1'b1;
    hold_cnt(n);
    chk("t3_hold_len", 32'(n), 32'(TMO_LIM));
    chk("t3_tmo_set", 32'(bus.tmo_err_o), 32'd1);
    wait_grant("t3b", gc);
    chk("t3_owner1", 32'(bus.owner_o), 32'd1);
    chk("t3_guard_len", 32'(gc), 32'(GUARD_P));
    repeat (3) cycle();
    bus.sdreq_i[1] = 1'b0;
    cycle();
    seen2 = 1'b0;
    repeat (12) begin
      cycle();
      seen2 |= bus.sdack_o[2];
    end
    chk("t3_ch2_locked", 32'(seen2), 32'd0);
    bus.sdreq_i[2] = 1'b0;
    cycle();
    bus.sdreq_i[2] = 1'b1;
    wait_grant("t3c", gc);
    chk("t3_ch2_regrant", 32'(bus.owner_o), 32'd2);
    bus.sdreq_i = 4'b0000;
    repeat (7) cycle();

    bus.err_clr_i = 1'b1;
    cycle();
    bus.err_clr_i = 1'b0;
    chk("t3_tmo_cleared", 32'(bus.tmo_err_o), 32'd0);

    // ch0 drops its request exactly on the expiry edge: ordinary release.
    bus.sdreq_i = 4'b0001;
    wait_grant("t4", gc);
    chk("t4_owner0", 32'(bus.owner_o), 32'd0);
    bus.sdreq_i[1] = 1'b1;
    repeat (TMO_LIM - 1) cycle();
    chk("t4_held", 32'(bus.sdack_o), 32'h1);
    bus.sdreq_i[0] = 1'b0;
    cycle();
    chk("t4_drop", 32'(bus.sdack_o), 32'h0);
    chk("t4_no_tmo", 32'(bus.tmo_err_o), 32'd0);
    wait_grant("t4b", gc);
    chk("t4_next_ch1", 32'(bus.owner_o), 32'd1);

    // ch1 times out on the same edge err_clr_i pulses: set wins; clear alone afterwards.
    bus.sdreq_i[0] = 1'b1;
    repeat (TMO_LIM - 1) cycle();
    bus.err_clr_i = 1'b1;
    cycle();
    chk("t5_tmo_drop", 32'(bus.sdack_o), 32'h0);
    chk("t5_set_wins", 32'(bus.tmo_err_o), 32'd1);
    cycle();
    bus.err_clr_i = 1'b0;
    chk("t5_clear", 32'(bus.tmo_err_o), 32'd0);
    wait_grant("t5b", gc);
    chk("t5_ch0_unlocked", 32'(bus.owner_o), 32'd0);
    bus.sdreq_i = 4'b0000;
    repeat (7) cycle();

    // Reset mid-grant of ch3; afterwards the scan restarts from ch0.
    bus.sdreq_i = 4'b1000;
    wait_grant("t6", gc);
    chk("t6_owner3", 32'(bus.owner_o), 32'd3);
    repeat (2) cycle();
    do_reset("t6_rst");
    bus.sdreq_i = 4'b1010;
    cycle();
    chk("t6_after_rst", 32'(bus.sdack_o), 32'h2);
    bus.sdreq_i = 4'b0000;
    repeat (7) cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(23, 0) == 0) bus.sdreq_i[k] = ~bus.sdreq_i[k];
      end
      bus.err_clr_i = ($urandom_range(15, 0) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
